// File: rtl/event_fifo_packer.sv
// Buffers tagger records in a FIFO and streams each one as three 16-bit words, LSW first.
// Optional OVERFLOW_MARKER_EN inserts a marker record after drops.
module event_fifo_packer #(
   parameter int N_CHANNELS = 4,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [42+N_CHANNELS:0]  in_data,
   input  logic                    in_ready,
   output logic [15:0]             out_word,
   output logic                    out_valid,
   input  logic                    out_ack,
   output logic [DEPTH_LOG2:0]     fill_level,
   output logic                    overflow,
   output logic [15:0]             lost_count,
   input  logic                    clear_overflow
);

   localparam int REC_W = 43 + N_CHANNELS;
   localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_W0   = 2'd1;
   localparam logic [1:0] S_W1   = 2'd2;
   localparam logic [1:0] S_W2   = 2'd3;

   logic [47:0]           mem [0:(1<<DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   fill_q, fill_d;
   logic [1:0]            state_q, state_d;
   logic [47:0]           hold_q;
   logic                  ovf_q;
   logic [15:0]           lost_q;
   logic                  full, empty, pop, wr_en, drop;
   logic [47:0]           rec_ext, wr_data;

   assign full  = (fill_q == DEPTH);
   assign empty = (fill_q == '0);

   always_comb begin
      rec_ext = '0;
      rec_ext[REC_W-1:0] = in_data;
   end

`ifdef OVERFLOW_MARKER_EN
   localparam int TYPE_BIT = 41 + N_CHANNELS;
   logic        mk_pend_q;
   logic [15:0] mk_cnt_q;
   logic        mk_wr;

   // While a marker is pending every arrival is dropped so the marker stays in order.
   assign mk_wr = mk_pend_q && !in_ready && !full;
   assign drop  = in_ready && (full || mk_pend_q);
   assign wr_en = (in_ready && !full && !mk_pend_q) || mk_wr;

   always_comb begin
      wr_data = rec_ext;
      if (mk_wr) begin
         wr_data = '0;
         wr_data[15:0] = mk_cnt_q;
         wr_data[TYPE_BIT] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mk_pend_q <= 1'b0;
         mk_cnt_q  <= '0;
      end else if (drop) begin
         mk_pend_q <= 1'b1;
         if (mk_cnt_q != 16'hFFFF) mk_cnt_q <= mk_cnt_q + 16'd1;
      end else if (mk_wr) begin
         mk_pend_q <= 1'b0;
         mk_cnt_q  <= '0;
      end
   end
`else
   assign drop    = in_ready && full;
   assign wr_en   = in_ready && !full;
   assign wr_data = rec_ext;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= wr_data;
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: if (!empty) begin pop = 1'b1; state_d = S_W0; end
         S_W0:   if (out_ack) state_d = S_W1;
         S_W1:   if (out_ack) state_d = S_W2;
         default: if (out_ack) begin
            if (!empty) begin pop = 1'b1; state_d = S_W0; end
            else state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      fill_d = fill_q;
      if (wr_en && !pop) fill_d = fill_q + (DEPTH_LOG2+1)'(1);
      else if (!wr_en && pop) fill_d = fill_q - (DEPTH_LOG2+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         fill_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
         ovf_q    <= 1'b0;
         lost_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            hold_q   <= mem[rd_ptr_q];
         end
         // A drop wins over a same-cycle clear and restarts the count at one.
         if (drop) begin
            ovf_q <= 1'b1;
            if (clear_overflow) lost_q <= 16'd1;
            else if (lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
         end else if (clear_overflow) begin
            ovf_q  <= 1'b0;
            lost_q <= '0;
         end
      end
   end

   always_comb begin
      case (state_q)
         S_W0:    out_word = hold_q[15:0];
         S_W1:    out_word = hold_q[31:16];
         S_W2:    out_word = hold_q[47:32];
         default: out_word = 16'h0000;
      endcase
   end

   assign out_valid  = (state_q != S_IDLE);
   assign fill_level = fill_q;
   assign overflow   = ovf_q;
   assign lost_count = lost_q;

endmodule

// File: tb/tb_event_fifo_packer.sv
// Directed bench for event_fifo_packer with N_CHANNELS=4 and a 4-entry FIFO.
module tb_event_fifo_packer;
   localparam int N  = 4;
   localparam int DL = 2;

   logic          clk = 1'b0;
   logic          reset, in_ready, out_ack, clear_overflow;
   logic [42+N:0] in_data;
   logic [15:0]   out_word, lost_count;
   logic          out_valid, overflow;
   logic [DL:0]   fill_level;

   int n_chk = 0;
   int n_fail = 0;

   event_fifo_packer #(.N_CHANNELS(N), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
      .out_word(out_word), .out_valid(out_valid), .out_ack(out_ack),
      .fill_level(fill_level), .overflow(overflow), .lost_count(lost_count),
      .clear_overflow(clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_ready = 1'b0; out_ack = 1'b0; clear_overflow = 1'b0; in_data = '0;
      #3;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_chk++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL reset_word: got %h want 0000", out_word); end
      n_chk++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      n_chk++; if (lost_count !== 16'd0) begin n_fail++; $display("FAIL reset_lost: got %0d want 0", lost_count); end
   endtask

   task automatic test_single();
      logic [15:0] exp [3];
      exp[0] = 16'h789A; exp[1] = 16'h3456; exp[2] = 16'h0012;
      in_data = 47'h0012_3456_789A; in_ready = 1'b1; out_ack = 1'b1;
      tick();
      in_ready = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_valid: got %b want 0", out_valid); end
      n_chk++; if (fill_level !== 3'd1) begin n_fail++; $display("FAIL single_lat_fill: got %0d want 1", fill_level); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid%0d: got %b want 1", i, out_valid); end
         n_chk++; if (out_word !== exp[i]) begin n_fail++; $display("FAIL single_word%0d: got %h want %h", i, out_word, exp[i]); end
      end
      tick();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp [6];
      exp[0] = 16'h3333; exp[1] = 16'h2222; exp[2] = 16'h1111;
      exp[3] = 16'h6666; exp[4] = 16'h5555; exp[5] = 16'h4444;
      out_ack = 1'b1;
      in_data = 47'h1111_2222_3333; in_ready = 1'b1;
      tick();
      in_data = 47'h4444_5555_6666;
      tick();
      in_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, out_valid); end
         n_chk++; if (out_word !== exp[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, out_word, exp[i]); end
         tick();
      end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp [9];
      logic [15:0] pat;
      logic [15:0] prev_word;
      logic        prev_stall, ack;
      int          idx;
      exp[0] = 16'h0303; exp[1] = 16'h0202; exp[2] = 16'h0101;
      exp[3] = 16'h0606; exp[4] = 16'h0505; exp[5] = 16'h0404;
      exp[6] = 16'h0909; exp[7] = 16'h0808; exp[8] = 16'h0707;
      pat = 16'b0110_1001_1101_0010;
      out_ack = 1'b0;
      in_ready = 1'b1;
      in_data = 47'h0101_0202_0303; tick();
      in_data = 47'h0404_0505_0606; tick();
      in_data = 47'h0707_0808_0909; tick();
      in_ready = 1'b0;
      idx = 0; prev_stall = 1'b0; prev_word = '0;
      for (int i = 0; i < 80 && idx < 9; i++) begin
         if (prev_stall) begin
            n_chk++; if (out_word !== prev_word) begin n_fail++; $display("FAIL bp_stable: got %h want %h", out_word, prev_word); end
         end
         ack = pat[i % 16];
         out_ack = ack;
         if (out_valid && ack) begin
            n_chk++; if (out_word !== exp[idx]) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", idx, out_word, exp[idx]); end
            idx++;
         end
         prev_stall = out_valid && !ack;
         prev_word  = out_word;
         tick();
      end
      out_ack = 1'b0;
      n_chk++; if (idx !== 9) begin n_fail++; $display("FAIL bp_count: got %0d want 9", idx); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      out_ack = 1'b0;
      // The first record moves into the holding register, so 7 arrivals overfill by 2.
      for (int k = 1; k <= 7; k++) begin
         in_data = 47'(k); in_ready = 1'b1;
         tick();
      end
      in_ready = 1'b0;
      n_chk++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL ovf_fill: got %0d want 4", fill_level); end
      n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      n_chk++; if (lost_count !== 16'd2) begin n_fail++; $display("FAIL ovf_lost: got %0d want 2", lost_count); end
   endtask

   task automatic test_collision();
      in_data = 47'h7FFF_FFFF_FFFF; in_ready = 1'b1; clear_overflow = 1'b1;
      tick();
      in_ready = 1'b0; clear_overflow = 1'b0;
      n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b want 1", overflow); end
      n_chk++; if (lost_count !== 16'd1) begin n_fail++; $display("FAIL coll_lost: got %0d want 1", lost_count); end
      n_chk++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL coll_fill: got %0d want 4", fill_level); end
   endtask

   task automatic test_clear();
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_flag: got %b want 0", overflow); end
      n_chk++; if (lost_count !== 16'd0) begin n_fail++; $display("FAIL clr_lost: got %0d want 0", lost_count); end
      n_chk++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL clr_fill: got %0d want 4", fill_level); end
   endtask

   // Drains what test_overflow left: records 1..5, then the marker when enabled.
   task automatic test_drain();
      logic [15:0] exp [18];
      int n_exp, idx;
      for (int k = 0; k < 5; k++) begin
         exp[3*k] = 16'(k + 1); exp[3*k+1] = 16'h0; exp[3*k+2] = 16'h0;
      end
`ifdef OVERFLOW_MARKER_EN
      exp[15] = 16'h0003; exp[16] = 16'h0000; exp[17] = 16'h2000;
      n_exp = 18;
`else
      exp[15] = 16'h0; exp[16] = 16'h0; exp[17] = 16'h0;
      n_exp = 15;
`endif
      idx = 0;
      out_ack = 1'b1;
      for (int i = 0; i < 60 && idx < n_exp; i++) begin
         if (out_valid) begin
            n_chk++; if (out_word !== exp[idx]) begin n_fail++; $display("FAIL drain_word%0d: got %h want %h", idx, out_word, exp[idx]); end
            idx++;
         end
         tick();
      end
      n_chk++; if (idx !== n_exp) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", idx, n_exp); end
      tick();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid: got %b want 0", out_valid); end
      n_chk++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL drain_fill: got %0d want 0", fill_level); end
      out_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_ready = 1'b1;
      in_data = 47'h1111_2222_3333; tick();
      in_data = 47'h4444_5555_6666; tick();
      in_ready = 1'b0;
      out_ack = 1'b1;
      tick();
      n_chk++; if (out_word !== 16'h2222) begin n_fail++; $display("FAIL rmid_pre_word: got %h want 2222", out_word); end
      #2 reset = 1'b1;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
      n_chk++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL rmid_fill: got %0d want 0", fill_level); end
      tick();
      reset = 1'b0;
      in_data = 47'h0777_0888_0999; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      tick();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_new_valid: got %b want 1", out_valid); end
      n_chk++; if (out_word !== 16'h0999) begin n_fail++; $display("FAIL rmid_new_word: got %h want 0999", out_word); end
      tick(); tick(); tick();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_end_valid: got %b want 0", out_valid); end
      out_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_collision();
      test_clear();
      test_drain();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
